fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, is the first fetch address after reset.
REQ-002 Parameter MAX_OUT, default 2, is the maximum number of outstanding imem requests; legal values 1..2.
REQ-003 Port clock, input, 1, is the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1, is an asynchronous, active-high reset.
REQ-005 Port imem_req, output, 1, is the instruction-memory request valid.
REQ-006 Port imem_addr, output, 32, is the word-aligned request address.
REQ-007 Port imem_gnt, input, 1, signals that memory accepted the request this cycle.
REQ-008 Port imem_rvalid, input, 1, signals that response data is valid; responses return in order, at least one cycle after grant.
REQ-009 Port imem_rdata, input, 32, is the response instruction word.
REQ-010 Port stall, input, 1, is asserted when decode cannot accept a new instruction.
REQ-011 Port redirect, input, 1, requests a branch/jump target from execute.
REQ-012 Port redirect_pc, input, 32, is the target address, qualified by redirect.
REQ-013 Port pc, output, 32, is the address of the instruction presented to decode.
REQ-014 Port insn, output, 32, is the instruction word presented to decode.
REQ-015 Port insn_valid, output, 1, is asserted when pc/insn hold a live instruction.

Function
REQ-016 The fetch PC (fpc) SHALL advance by 4 on each cycle in which imem_req and imem_gnt are both high.
- fpc is 32-bit and wraps modulo 2^32.
REQ-017 imem_req SHALL be high in RUN only when outstanding + buffered < 2 and outstanding < MAX_OUT.
- imem_addr = {fpc[31:2],2'b00}.
REQ-018 A response SHALL enter the 2-entry buffer tagged with its request address.
- The buffer never overflows, by construction of REQ-017.
REQ-019 When stall=0 and the buffer is non-empty, the head SHALL move to pc/insn with insn_valid=1 on the next edge.
- When stall=0 and the buffer is empty, insn_valid SHALL go to 0.
- Response-to-output latency is one cycle when the buffer is empty.
REQ-020 While stall=1, pc, insn and insn_valid SHALL hold their values.
REQ-021 On redirect=1, the following SHALL all take effect on the same edge:
- fpc <= redirect_pc;
- the buffer is flushed;
- insn_valid <= 0;
- drop_cnt <= outstanding minus any response arriving that cycle.
- redirect takes priority over stall, grant and response in the same cycle.
REQ-022 The FSM SHALL have two states, RUN and FLUSH.
- RUN -> FLUSH on redirect when drop_cnt will be non-zero.
- FLUSH -> RUN when drop_cnt reaches 0.
- In FLUSH, imem_req=0 and each imem_rvalid is discarded and decrements drop_cnt.
- A redirect received in FLUSH reloads fpc and keeps the FSM in FLUSH.
REQ-023 imem_rvalid with zero outstanding requests is a protocol error; it SHALL be ignored, with an assertion in simulation.

Reset
REQ-024 Reset SHALL asynchronously set the following:
- fpc=RESET_PC, FSM=RUN, outstanding=0, drop_cnt=0, buffer empty.
- imem_req=0, insn_valid=0, pc=0, insn=32'h0000_0000.
REQ-025 Reset asserted mid-transaction SHALL abandon all outstanding requests.
- imem_req SHALL go high no earlier than the first edge after reset deasserts.

Configuration
REQ-026 When FETCH_BUBBLE_NOP_EN is defined, insn SHALL be driven to 32'h0000_0000 (NOP) in every cycle where insn_valid=0.
- When FETCH_BUBBLE_NOP_EN is undefined, insn SHALL retain its last value while insn_valid=0.

Structure
REQ-027 Shared package mips_pkg SHALL hold the following:
- the NOP encoding;
- the default reset PC;
- the FSM state typedef (RUN, FLUSH);
- the instruction/address width constants.
REQ-028 The 2-entry buffer SHALL be a sub-module fetch_buf with push, pop, flush, full, empty and a 64-bit {pc,insn} payload.

Verification
REQ-029 Sequential fetch scenario:
- Stimulus: reset release, memory always granting with 1-cycle response latency, stall=0.
- Required response: imem_addr = 0x00400000, 0x00400004, 0x00400008 on consecutive cycles, and pc follows two cycles later with insn_valid=1.
REQ-030 Stall scenario:
- Stimulus: stall=1 for 4 cycles.
- Required response: pc/insn hold, at most 2 instructions are buffered, imem_req drops, and no instruction is lost after stall release.
REQ-031 Redirect with outstanding requests:
- Stimulus: redirect to 0x00400100 while 2 requests are outstanding.
- Required response: both stale responses are dropped, FSM passes through FLUSH, and the next valid pc is 0x00400100.
REQ-032 Simultaneous events:
- Stimulus: redirect, stall=1 and imem_rvalid in the same cycle.
- Required response: redirect wins, insn_valid=0, and the arriving response is dropped.
REQ-033 Wrap-around:
- Stimulus: redirect to 0xFFFFFFFC.
- Required response: the next request address is 0x00000000.
REQ-034 Macro and reset checks:
- With FETCH_BUBBLE_NOP_EN defined, insn is 0 during bubbles.
- Reset asserted mid-flush clears drop_cnt, and the first request after release goes to RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: widths, NOP encoding,
// default reset PC, fetch FSM states and the buffered {pc,insn} payload.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP              = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-side handshake and the execute redirect.
interface fetch_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
    logic            insn_valid;

    modport master (
        output imem_req, imem_addr, pc, insn, insn_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, pc, insn, insn_valid,
        output imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding returned instructions tagged with their fetch address.
// The caller never pushes when full or pops when empty.
module fetch_buf
    import mips_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  fetch_pkt_t push_data_i,
    output fetch_pkt_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    fetch_pkt_t mem_q [2];
    logic       rd_q;
    logic       wr_q;
    logic [1:0] cnt_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop_i)  rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // NOTE: payload storage is not reset; cnt_q alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues imem requests, tags in-order responses, feeds decode.
// Build option FETCH_BUBBLE_NOP_EN: insn reads as NOP whenever insn_valid is low.
module fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     MAX_OUT  = 2
) (
    input  logic    clock,
    input  logic    reset,
    fetch_if.master bus
);

    localparam logic [1:0] MaxOut = 2'(MAX_OUT);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] insn_q, insn_d;
    logic            valid_q, valid_d;
    logic [1:0]      out_q, out_d;
    logic [1:0]      drop_q, drop_d;
    logic            req_en_q;

    logic            buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    logic [1:0]      buffered;
    fetch_pkt_t      buf_head, rsp_pkt;
    logic            rsp, fire;

    assign buffered = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp      = bus.imem_rvalid && (out_q != 2'd0);
    assign rsp_pkt  = '{pc: rpc_q, insn: bus.imem_rdata};

    // Held low during redirect so a grant can never race the flush.
    assign bus.imem_req  = req_en_q && (state_q == RUN) && !bus.redirect
                        && (({1'b0, out_q} + {1'b0, buffered}) < 3'd2)
                        && (out_q < MaxOut);
    assign bus.imem_addr = word_align(fpc_q);
    assign fire          = bus.imem_req && bus.imem_gnt;

    fetch_buf u_buf (
        .clock       (clock),
        .reset       (reset),
        .push_i      (buf_push),
        .pop_i       (buf_pop),
        .flush_i     (buf_flush),
        .push_data_i (rsp_pkt),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d   = state_q;
        fpc_d     = fire ? fpc_q + 32'd4 : fpc_q;
        rpc_d     = rpc_q;
        out_d     = out_q + {1'b0, fire} - {1'b0, rsp};
        drop_d    = drop_q;
        pc_d      = pc_q;
        insn_d    = insn_q;
        valid_d   = valid_q;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        buf_flush = 1'b0;

        if (bus.redirect) begin
            fpc_d     = bus.redirect_pc;
            rpc_d     = bus.redirect_pc;
            buf_flush = 1'b1;
            valid_d   = 1'b0;
            drop_d    = out_q - {1'b0, rsp};
            state_d   = ((drop_d != 2'd0) || (state_q == FLUSH)) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            drop_d = drop_q - {1'b0, rsp};
            if (drop_d == 2'd0) state_d = RUN;
        end else begin
            rpc_d = rsp ? rpc_q + 32'd4 : rpc_q;
            if (bus.stall) begin
                buf_push = rsp;
            end else if (!buf_empty) begin
                buf_pop  = 1'b1;
                buf_push = rsp;
                pc_d     = buf_head.pc;
                insn_d   = buf_head.insn;
                valid_d  = 1'b1;
            end else begin
                // Empty buffer: the arriving response bypasses straight to decode.
                valid_d = rsp;
                if (rsp) begin
                    pc_d   = rpc_q;
                    insn_d = bus.imem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            fpc_q    <= RESET_PC;
            rpc_q    <= RESET_PC;
            out_q    <= 2'd0;
            drop_q   <= 2'd0;
            pc_q     <= '0;
            insn_q   <= NOP;
            valid_q  <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            rpc_q    <= rpc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            pc_q     <= pc_d;
            insn_q   <= insn_d;
            valid_q  <= valid_d;
            req_en_q <= 1'b1;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.insn_valid = valid_q;
`ifdef FETCH_BUBBLE_NOP_EN
    assign bus.insn       = valid_q ? insn_q : NOP;
`else
    assign bus.insn       = insn_q;
`endif

    rvalid_needs_outstanding: assert property (
        @(posedge clock) disable iff (reset) bus.imem_rvalid |-> (out_q != 2'd0)
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: vector table over a small in-order memory model,
// then a reset-during-flush sequence.
module tb_fetch;
    import mips_pkg::*;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        hold;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        flush;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_if bus ();

    fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    logic [31:0] last_insn = 32'h0;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] rpc,
                                input logic hold, input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] pc, input logic flush);
        vec_t v;
        v.stall = stall; v.redir = redir; v.rpc = rpc; v.gnt = 1'b1; v.hold = hold;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.flush = flush;
        return v;
    endfunction

    // Memory answers the oldest granted address with ~addr, one cycle after grant, unless held.
    task automatic apply(input vec_t v, input string tag);
        logic        fire;
        logic        rsp;
        logic [31:0] addr;
        logic [31:0] exp_insn;
        bus.stall       = v.stall;
        bus.redirect    = v.redir;
        bus.redirect_pc = v.rpc;
        bus.imem_gnt    = v.gnt;
        rsp             = (mq.size() != 0) && !v.hold;
        bus.imem_rvalid = rsp;
        bus.imem_rdata  = rsp ? ~mq[0] : 32'h0;
        #1;
        check({tag, " imem_req"}, {31'b0, bus.imem_req}, {31'b0, v.req});
        if (v.req) check({tag, " imem_addr"}, bus.imem_addr, v.addr);
        fire = bus.imem_req && bus.imem_gnt;
        addr = bus.imem_addr;
        @(posedge clock);
        if (rsp) void'(mq.pop_front());
        if (fire) mq.push_back(addr);
        @(negedge clock);
        if (v.valid) begin
            exp_insn  = ~v.pc;
            last_insn = exp_insn;
        end else begin
`ifdef FETCH_BUBBLE_NOP_EN
            exp_insn = 32'h0;
`else
            exp_insn = last_insn;
`endif
        end
        check({tag, " insn_valid"}, {31'b0, bus.insn_valid}, {31'b0, v.valid});
        check({tag, " pc"}, bus.pc, v.pc);
        check({tag, " insn"}, bus.insn, exp_insn);
        check({tag, " flush_state"}, {31'b0, dut.state_q == FLUSH}, {31'b0, v.flush});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //             stall redir rpc           hold req addr          valid pc            flush
        vecs.push_back(mk(0, 0, 32'h0,           0,   0, 32'h0,         0, 32'h0,         0)); // v0
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0000, 0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0004, 1, 32'h0040_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0008, 1, 32'h0040_0004, 0));
        vecs.push_back(mk(1, 0, 32'h0,           0,   1, 32'h0040_000C, 1, 32'h0040_0004, 0)); // v4 stall
        vecs.push_back(mk(1, 0, 32'h0,           0,   0, 32'h0,         1, 32'h0040_0004, 0));
        vecs.push_back(mk(1, 0, 32'h0,           0,   0, 32'h0,         1, 32'h0040_0004, 0));
        vecs.push_back(mk(1, 0, 32'h0,           0,   0, 32'h0,         1, 32'h0040_0004, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   0, 32'h0,         1, 32'h0040_0008, 0)); // v8 drain
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0010, 1, 32'h0040_000C, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0014, 1, 32'h0040_0010, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0018, 1, 32'h0040_0014, 0));
        vecs.push_back(mk(0, 0, 32'h0,           1,   1, 32'h0040_001C, 0, 32'h0040_0014, 0)); // v12 two out
        vecs.push_back(mk(0, 1, 32'h0040_0100,   1,   0, 32'h0,         0, 32'h0040_0014, 1));
        vecs.push_back(mk(0, 0, 32'h0,           0,   0, 32'h0,         0, 32'h0040_0014, 1));
        vecs.push_back(mk(0, 0, 32'h0,           0,   0, 32'h0,         0, 32'h0040_0014, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0100, 0, 32'h0040_0014, 0)); // v16
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0104, 1, 32'h0040_0100, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0108, 1, 32'h0040_0104, 0));
        vecs.push_back(mk(1, 1, 32'h0040_0200,   0,   0, 32'h0,         0, 32'h0040_0104, 0)); // v19 all at once
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0200, 0, 32'h0040_0104, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0204, 1, 32'h0040_0200, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0040_0208, 1, 32'h0040_0204, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,   0,   0, 32'h0,         0, 32'h0040_0204, 0)); // v23 wrap
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'hFFFF_FFFC, 0, 32'h0040_0204, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 32'h0,           0,   1, 32'h0000_0004, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,           1,   1, 32'h0000_0008, 0, 32'h0000_0000, 0)); // v27
        vecs.push_back(mk(0, 1, 32'h0040_0300,   1,   0, 32'h0,         0, 32'h0000_0000, 1));

        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;

        repeat (2) @(negedge clock);
        #1;
        check("reset imem_req", {31'b0, bus.imem_req}, 32'h0);
        check("reset insn_valid", {31'b0, bus.insn_valid}, 32'h0);
        check("reset pc", bus.pc, 32'h0);
        check("reset insn", bus.insn, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Reset while two stale responses are still owed.
        check("midflush drop_cnt", {30'b0, dut.drop_q}, 32'd2);
        bus.redirect = 1'b0; bus.imem_rvalid = 1'b0; bus.stall = 1'b0;
        reset = 1'b1;
        #1;
        check("midflush reset drop_cnt", {30'b0, dut.drop_q}, 32'd0);
        check("midflush reset state", {31'b0, dut.state_q == FLUSH}, 32'h0);
        check("midflush reset imem_req", {31'b0, bus.imem_req}, 32'h0);
        check("midflush reset insn_valid", {31'b0, bus.insn_valid}, 32'h0);
        check("midflush reset pc", bus.pc, 32'h0);
        mq.delete();
        last_insn = 32'h0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h0,         0), "rel0");
        apply(mk(0, 0, 32'h0, 0, 1, 32'h0040_0000, 0, 32'h0,         0), "rel1");
        apply(mk(0, 0, 32'h0, 0, 1, 32'h0040_0004, 1, 32'h0040_0000, 0), "rel2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
